// File: rtl/regwr_decode_pipe_if.sv
// regwr_decode_pipe_if: write-request and write-select bundle between writeback and the register-file decoder
// Ports carried: stall, flush, cnt_clr, wr0_en/wr0_addr, wr1_en/wr1_addr (to decoder);
//                sel0, sel1, coll, coll_cnt (from decoder)
interface regwr_decode_pipe_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
);
  localparam int NREG = 2**ADDR_W;
  logic              stall;
  logic              flush;
  logic              cnt_clr;
  logic              wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [NREG-1:0]   sel0;
  logic [NREG-1:0]   sel1;
  logic              coll;
  logic [CNT_W-1:0]  coll_cnt;
  modport master (
    output stall, flush, cnt_clr, wr0_en, wr0_addr, wr1_en, wr1_addr,
    input  sel0, sel1, coll, coll_cnt
  );
  modport slave (
    input  stall, flush, cnt_clr, wr0_en, wr0_addr, wr1_en, wr1_addr,
    output sel0, sel1, coll, coll_cnt
  );
endinterface

// File: rtl/regwr_decode_pipe.sv
// regwr_decode_pipe: dual-port registered register-file write-select decoder with zero-register masking and collision resolution
// Ports: clk, reset_n (async active-low); bus (slave) carries stall/flush/cnt_clr,
//        two write requests, and the registered sel0/sel1/coll/coll_cnt outputs
module regwr_decode_pipe #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  regwr_decode_pipe_if.slave  bus
);
  localparam int NREG = 2**ADDR_W;
  logic [NREG-1:0] d0, d1;
  logic            hit;
  for (genvar i = 0; i < NREG; i++) begin : g_dec
    localparam bit Z = (ZERO_EN != 0) && (i == ZERO_REG);
    assign d0[i] = bus.wr0_en && (bus.wr0_addr == ADDR_W'(i)) && !Z;
    assign d1[i] = bus.wr1_en && (bus.wr1_addr == ADDR_W'(i)) && !Z;
  end
  // the younger port 1 wins a same-register collision
  assign hit = |(d0 & d1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.sel0     <= '0;
      bus.sel1     <= '0;
      bus.coll     <= 1'b0;
      bus.coll_cnt <= '0;
    end else begin
      if (bus.flush) begin
        bus.sel0 <= '0;
        bus.sel1 <= '0;
        bus.coll <= 1'b0;
      end else if (!bus.stall) begin
        bus.sel0 <= hit ? '0 : d0;
        bus.sel1 <= d1;
        bus.coll <= hit;
      end
      if (bus.cnt_clr)
        bus.coll_cnt <= '0;
      else if (!bus.flush && !bus.stall && hit && bus.coll_cnt != '1)
        bus.coll_cnt <= bus.coll_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_regwr_decode_pipe.sv
// tb_regwr_decode_pipe: directed self-checking bench for two decoder configurations (CNT_W=2 with zero masking, ZERO_EN=0)
module tb_regwr_decode_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  regwr_decode_pipe_if #(.ADDR_W(5), .CNT_W(2)) ia ();
  regwr_decode_pipe_if #(.ADDR_W(5), .CNT_W(8)) ib ();
  regwr_decode_pipe #(.ADDR_W(5), .ZERO_EN(1), .ZERO_REG(31), .CNT_W(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia)
  );
  regwr_decode_pipe #(.ADDR_W(5), .ZERO_EN(0), .ZERO_REG(31), .CNT_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set(input logic s, input logic f, input logic c,
                     input logic e0, input logic [4:0] a0,
                     input logic e1, input logic [4:0] a1);
    ia.stall = s; ia.flush = f; ia.cnt_clr = c;
    ia.wr0_en = e0; ia.wr0_addr = a0; ia.wr1_en = e1; ia.wr1_addr = a1;
    ib.stall = s; ib.flush = f; ib.cnt_clr = c;
    ib.wr0_en = e0; ib.wr0_addr = a0; ib.wr1_en = e1; ib.wr1_addr = a1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk("a_disjoint", ia.sel0 & ia.sel1, 32'h0);
    chk("b_disjoint", ib.sel0 & ib.sel1, 32'h0);
  endtask
  task automatic chk_a(input string tag, input logic [31:0] s0, input logic [31:0] s1,
                       input logic c, input logic [1:0] n);
    chk({tag, "_sel0"}, ia.sel0, s0);
    chk({tag, "_sel1"}, ia.sel1, s1);
    chk({tag, "_coll"}, 32'(ia.coll), 32'(c));
    chk({tag, "_cnt"}, 32'(ia.coll_cnt), 32'(n));
  endtask
  initial begin
    set(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_a("reset", 32'h0, 32'h0, 1'b0, 2'd0);
    chk("reset_b_cnt", 32'(ib.coll_cnt), 32'h0);
    reset_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      logic [31:0] e;
      e = (a == 31) ? 32'h0 : (32'h1 << a);
      set(0, 0, 0, 1, 5'(a), 0, 0);
      tick();
      chk_a($sformatf("exh%0d", a), e, 32'h0, 1'b0, 2'd0);
      chk($sformatf("exh%0d_b", a), ib.sel0, 32'h1 << a);
    end
    set(0, 0, 0, 1, 7, 1, 7);
    tick();
    chk_a("coll7", 32'h0, 32'h80, 1'b1, 2'd1);
    chk("coll7_b_cnt", 32'(ib.coll_cnt), 32'd1);
    set(0, 0, 0, 1, 31, 1, 31);
    tick();
    chk_a("coll31", 32'h0, 32'h0, 1'b0, 2'd1);
    chk("coll31_b_sel0", ib.sel0, 32'h0);
    chk("coll31_b_sel1", ib.sel1, 32'h8000_0000);
    chk("coll31_b_coll", 32'(ib.coll), 32'd1);
    chk("coll31_b_cnt", 32'(ib.coll_cnt), 32'd2);
    set(0, 0, 0, 1, 3, 1, 9);
    tick();
    chk_a("diff", 32'h8, 32'h200, 1'b0, 2'd1);
    set(1, 0, 0, 1, 5, 1, 5);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_a($sformatf("stall%0d", k), 32'h8, 32'h200, 1'b0, 2'd1);
      chk($sformatf("stall%0d_b_cnt", k), 32'(ib.coll_cnt), 32'd2);
    end
    set(1, 1, 0, 1, 4, 1, 4);
    tick();
    chk_a("flush_stall", 32'h0, 32'h0, 1'b0, 2'd1);
    set(0, 0, 0, 1, 2, 1, 6);
    tick();
    chk_a("cap26", 32'h4, 32'h40, 1'b0, 2'd1);
    set(0, 1, 0, 1, 2, 1, 2);
    tick();
    chk_a("flush", 32'h0, 32'h0, 1'b0, 2'd1);
    chk("flush_b_cnt", 32'(ib.coll_cnt), 32'd2);
    set(1, 0, 1, 0, 0, 0, 0);
    tick();
    chk_a("clr_stall", 32'h0, 32'h0, 1'b0, 2'd0);
    chk("clr_stall_b_cnt", 32'(ib.coll_cnt), 32'd0);
    set(0, 0, 1, 1, 1, 1, 1);
    tick();
    chk_a("clr_prio", 32'h0, 32'h2, 1'b1, 2'd0);
    for (int k = 0; k < 5; k++) begin
      set(0, 0, 0, 1, 10, 1, 10);
      tick();
      chk_a($sformatf("sat%0d", k), 32'h0, 32'h400, 1'b1, (k >= 2) ? 2'd3 : 2'(k + 1));
      chk($sformatf("sat%0d_b_cnt", k), 32'(ib.coll_cnt), 32'(k + 1));
    end
    set(0, 0, 0, 0, 0, 1, 12);
    tick();
    chk_a("pre_rst", 32'h0, 32'h1000, 1'b0, 2'd3);
    set(1, 0, 0, 0, 0, 1, 13);
    #2;
    reset_n = 1'b0;
    #1;
    chk_a("async_rst", 32'h0, 32'h0, 1'b0, 2'd0);
    chk("async_rst_b_cnt", 32'(ib.coll_cnt), 32'd0);
    #2;
    reset_n = 1'b1;
    set(0, 0, 0, 0, 0, 1, 0);
    tick();
    chk_a("post_rst", 32'h0, 32'h1, 1'b0, 2'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
